data_mem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_ram.sv | 27 ++
 rtl/data_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory stage: MMIO register
// offsets, status bit positions and the load FSM state encoding.
package dmem_pkg;

   // Register offsets inside the MMIO window (relative to MMIO_BASE)
   localparam logic [1:0] OFF_GPIO_OUT = 2'd0;
   localparam logic [1:0] OFF_GPIO_IN  = 2'd1;
   localparam logic [1:0] OFF_CYCLE    = 2'd2;
   localparam logic [1:0] OFF_STATUS   = 2'd3;

   // Number of implemented MMIO registers; anything above is unmapped
   localparam int MMIO_REGS = 4;

   // Status register bit positions
   localparam int ST_ILLEGAL  = 0;
   localparam int ST_UNMAPPED = 1;
   localparam int ST_W        = 2;

   // Free-running cycle counter width
   localparam int CYCLE_W = 32;

   // Load FSM: IDLE accepts requests, RD_DONE presents the load result
   typedef enum logic {
      IDLE    = 1'b0,
      RD_DONE = 1'b1
   } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM. One-cycle read latency, no reset,
// written so synthesis maps it onto block RAM.
import dmem_pkg::*;

module dmem_ram #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int WORDS  = 3840
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [WORDS];

   // Write on we; registered read of the addressed word every cycle
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage behind the cpu load/store port. Word RAM below
// MMIO_BASE, four MMIO registers (GPIO out/in, cycle counter, status) above.
// Loads take one stall cycle because the RAM read is synchronous.
//
// Handshake: there is no valid/ready pair. A load is accepted in IDLE when
// mem_rd=1 and mem_wr=0; mem_stall is high combinationally in that issue
// cycle and the data is on data_mem_out throughout the following (RD_DONE)
// cycle, in which mem_rd/mem_wr are ignored. Stores complete in the IDLE
// cycle that presents them, with no stall.
import dmem_pkg::*;

module data_mem_ctrl #(
   parameter int          ADDR_W    = 12,
   parameter int          DATA_W    = 32,
   parameter int unsigned MMIO_BASE = 'hF00,
   parameter int          RAM_WORDS = 3840
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] data_mem_in,
   output logic [DATA_W-1:0] data_mem_out,
   output logic              mem_stall,
   input  logic [DATA_W-1:0] gpio_in,
   output logic [DATA_W-1:0] gpio_out,
   output state_e            dbg_state
);

   localparam logic [ADDR_W-1:0] MMIO_BASE_A = ADDR_W'(MMIO_BASE);
   localparam logic [ADDR_W-1:0] MMIO_REGS_A = ADDR_W'(MMIO_REGS);

   state_e              state_q, state_d;
   logic                rd_issue, wr_go, illegal;
   logic                is_mmio, is_ram, is_reg, is_unmapped;
   logic [ADDR_W-1:0]   mmio_off;
   logic [1:0]          reg_sel;
   logic [DATA_W-1:0]   mmio_rdata, mmio_q, hold_q, ram_rdata, load_data;
   logic                rd_is_ram_q;
   logic [DATA_W-1:0]   gpio_meta_q, gpio_sync_q;
   logic [CYCLE_W-1:0]  cycle_cnt_q;
   logic [ST_W-1:0]     status_q, st_set, st_clr;

   // Address decode: RAM below MMIO_BASE, four registers, then unmapped
   always_comb begin
      is_mmio     = (ram_addr >= MMIO_BASE_A);
      is_ram      = !is_mmio;
      mmio_off    = ram_addr - MMIO_BASE_A;
      is_reg      = is_mmio && (mmio_off < MMIO_REGS_A);
      is_unmapped = is_mmio && !is_reg;
      reg_sel     = mmio_off[1:0];
   end

   // FSM next state and request qualification; stall only on load issue
   always_comb begin
      state_d   = state_q;
      rd_issue  = 1'b0;
      wr_go     = 1'b0;
      illegal   = 1'b0;
      mem_stall = 1'b0;
      case (state_q)
         IDLE: begin
            wr_go    = mem_wr;
            illegal  = mem_rd && mem_wr;
            rd_issue = mem_rd && !mem_wr;
            if (rd_issue) begin
               mem_stall = 1'b1;
               state_d   = RD_DONE;
            end
         end
         RD_DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   assign dbg_state = state_q;

   // MMIO read mux; unmapped addresses read as zero
   always_comb begin
      mmio_rdata = '0;
      if (is_reg) begin
         case (reg_sel)
            OFF_GPIO_OUT: mmio_rdata = gpio_out;
            OFF_GPIO_IN:  mmio_rdata = gpio_sync_q;
            OFF_CYCLE:    mmio_rdata = DATA_W'(cycle_cnt_q);
            OFF_STATUS:   mmio_rdata = DATA_W'(status_q);
            default:      mmio_rdata = '0;
         endcase
      end
   end

   // Capture the MMIO value and the RAM/MMIO source at the issue edge
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_is_ram_q <= 1'b0;
         mmio_q      <= '0;
      end else if (rd_issue) begin
         rd_is_ram_q <= is_ram;
         mmio_q      <= mmio_rdata;
      end
   end

   dmem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .WORDS  (RAM_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (wr_go && is_ram),
      .addr  (ram_addr),
      .wdata (data_mem_in),
      .rdata (ram_rdata)
   );

   // In RD_DONE the load result comes straight from registered sources
   assign load_data    = rd_is_ram_q ? ram_rdata : mmio_q;
   assign data_mem_out = (state_q == RD_DONE) ? load_data : hold_q;

   // Keep the last load result visible until the next load completes
   always_ff @(posedge clk) begin
      if (reset)                  hold_q <= '0;
      else if (state_q == RD_DONE) hold_q <= load_data;
   end

   // GPIO output register
   always_ff @(posedge clk) begin
      if (reset) gpio_out <= '0;
      else if (wr_go && is_reg && reg_sel == OFF_GPIO_OUT) gpio_out <= data_mem_in;
   end

   // Two-flop synchroniser for the asynchronous GPIO inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_meta_q <= '0;
         gpio_sync_q <= '0;
      end else begin
         gpio_meta_q <= gpio_in;
         gpio_sync_q <= gpio_meta_q;
      end
   end

   // Free-running cycle counter, wraps naturally
   always_ff @(posedge clk) begin
      if (reset) cycle_cnt_q <= '0;
      else       cycle_cnt_q <= cycle_cnt_q + 1'b1;
   end

   // Status set events and write-1-to-clear mask
   always_comb begin
      st_set              = '0;
      st_clr              = '0;
      st_set[ST_ILLEGAL]  = illegal;
      st_set[ST_UNMAPPED] = (rd_issue || wr_go) && is_unmapped;
      if (wr_go && is_reg && reg_sel == OFF_STATUS) begin
         st_clr = data_mem_in[ST_W-1:0];
      end
   end

   // Sticky status; a set in the same cycle as a clear wins
   always_ff @(posedge clk) begin
      if (reset) status_q <= '0;
      else       status_q <= (status_q & ~st_clr) | st_set;
   end

   // Request strobes must never be unknown outside reset
   a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
      !$isunknown({mem_rd, mem_wr}))
      else $error("mem_rd/mem_wr unknown");

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: RAM store/load, GPIO, cycle counter
// wrap, status sticky/W1C behaviour, unmapped accesses and mid-read reset.
import dmem_pkg::*;

module tb_data_mem_ctrl;

   logic        clk;
   logic        reset;
   logic        mem_rd;
   logic        mem_wr;
   logic [11:0] ram_addr;
   logic [31:0] data_mem_in;
   logic [31:0] data_mem_out;
   logic        mem_stall;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;
   state_e      dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   data_mem_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .ram_addr     (ram_addr),
      .data_mem_in  (data_mem_in),
      .data_mem_out (data_mem_out),
      .mem_stall    (mem_stall),
      .gpio_in      (gpio_in),
      .gpio_out     (gpio_out),
      .dbg_state    (dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Load: stall in issue cycle, data in RD_DONE, held afterwards
   task automatic do_load(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      mem_rd   = 1'b1;
      mem_wr   = 1'b0;
      ram_addr = addr;
      #1 check({tag, " issue stall"}, 32'(mem_stall), 32'd1);
      step();
      mem_rd = 1'b0;
      #1;
      check({tag, " state"}, 32'(dbg_state), 32'(RD_DONE));
      check({tag, " done stall"}, 32'(mem_stall), 32'd0);
      check({tag, " data"}, data_mem_out, exp);
      step();
      #1 check({tag, " hold"}, data_mem_out, exp);
   endtask

   // Store (optionally with a simultaneous read request): never stalls
   task automatic do_store(input string tag, input logic [11:0] addr, input logic [31:0] data,
                           input logic with_rd);
      mem_rd      = with_rd;
      mem_wr      = 1'b1;
      ram_addr    = addr;
      data_mem_in = data;
      #1 check({tag, " stall"}, 32'(mem_stall), 32'd0);
      step();
      mem_rd = 1'b0;
      mem_wr = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      ram_addr    = '0;
      data_mem_in = '0;
      gpio_in     = '0;
      repeat (3) step();
      #1;
      check("rst data_mem_out", data_mem_out, 32'd0);
      check("rst gpio_out", gpio_out, 32'd0);
      check("rst stall", 32'(mem_stall), 32'd0);
      check("rst state", 32'(dbg_state), 32'(IDLE));
      reset = 1'b0;
      step();

      // RAM store then load, including both ends of the RAM range
      do_store("st 010", 12'h010, 32'hDEADBEEF, 1'b0);
      do_load("ld 010", 12'h010, 32'hDEADBEEF);
      do_store("st 000", 12'h000, 32'h0000_0001, 1'b0);
      do_store("st EFF", 12'hEFF, 32'h8000_0000, 1'b0);
      do_load("ld EFF", 12'hEFF, 32'h8000_0000);
      do_load("ld 000", 12'h000, 32'h0000_0001);

      // GPIO out write and synchronised GPIO in read
      do_store("st gpio", 12'hF00, 32'h0000_00A5, 1'b0);
      #1 check("gpio_out", gpio_out, 32'h0000_00A5);
      gpio_in = 32'h0000_1234;
      repeat (3) step();
      do_load("ld gpio_in", 12'hF01, 32'h0000_1234);
      do_load("ld gpio_out", 12'hF00, 32'h0000_00A5);

      // Cycle counter wrap: sampled in the issue cycle
      force dut.cycle_cnt_q = 32'hFFFF_FFFE;
      step();
      release dut.cycle_cnt_q;
      do_load("ld cyc0", 12'hF02, 32'hFFFF_FFFE);
      do_load("ld cyc1", 12'hF02, 32'h0000_0000);

      // Simultaneous rd+wr: write happens, read dropped, illegal flagged
      do_store("rdwr 020", 12'h020, 32'h0000_0007, 1'b1);
      #1 check("rdwr state", 32'(dbg_state), 32'(IDLE));
      do_load("ld 020", 12'h020, 32'h0000_0007);
      do_load("ld st illegal", 12'hF03, 32'h0000_0001);
      do_store("w1c illegal", 12'hF03, 32'h0000_0001, 1'b0);
      do_load("ld st clear", 12'hF03, 32'h0000_0000);

      // Unmapped accesses: read zero, writes ignored, status bit1 sticky
      do_load("ld unmapped", 12'hF10, 32'h0000_0000);
      do_load("ld st unmapped", 12'hF03, 32'h0000_0002);
      do_store("st unmapped", 12'hF10, 32'hFFFF_FFFF, 1'b0);
      #1 check("gpio after unmapped", gpio_out, 32'h0000_00A5);
      do_load("ld 010 after unmapped", 12'h010, 32'hDEADBEEF);

      // RO write ignored; set wins over W1C clear in the same cycle
      do_store("st ro cycle", 12'hF02, 32'h0000_0003, 1'b0);
      do_load("ld st after ro", 12'hF03, 32'h0000_0002);
      do_store("rdwr w1c", 12'hF03, 32'h0000_0003, 1'b1);
      do_load("ld st set wins", 12'hF03, 32'h0000_0001);
      do_store("w1c all", 12'hF03, 32'h0000_0003, 1'b0);
      do_load("ld st zero", 12'hF03, 32'h0000_0000);

      // Reset during RD_DONE discards the load
      do_load("ld pre reset", 12'h020, 32'h0000_0007);
      mem_rd   = 1'b1;
      ram_addr = 12'h010;
      step();
      mem_rd = 1'b0;
      reset  = 1'b1;
      #1 check("mid state", 32'(dbg_state), 32'(RD_DONE));
      step();
      reset = 1'b0;
      #1;
      check("post rst state", 32'(dbg_state), 32'(IDLE));
      check("post rst data", data_mem_out, 32'd0);
      check("post rst stall", 32'(mem_stall), 32'd0);
      check("post rst gpio", gpio_out, 32'd0);
      step();
      do_load("ld 010 after rst", 12'h010, 32'hDEADBEEF);
      do_load("ld 020 after rst", 12'h020, 32'h0000_0007);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
